pixel_coord_tracker: RTL and testbench

- Sits directly upstream of the crop stage on the camera pixel AXI-Stream.
- Passes pixels through a registered, full-throughput skid stage. Each output beat carries its (column, row) coordinate, which drives the crop stage's cnt_col/cnt_row inputs.
- Derives geometry from tuser framing flags and beat counting.
- Flags sync and line-length errors and counts completed frames.

---
 rtl/pixel_coord_tracker.sv | 126 ++++++++++++
 tb/tb_pixel_coord_tracker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_coord_tracker.sv
// pixel_coord_tracker: tags each AXI-Stream pixel with its (col,row) and checks frame framing.
// Ports:
//   clk, s_axis_resetn    pixel clock, asynchronous active-low reset
//   err_clear             pulse that clears the sticky error flags
//   s_axis_*              upstream pixel stream (tuser[0]=SOF, tuser[1]=EOL)
//   m_axis_*              downstream pixel stream, one register stage plus skid
//   cnt_col, cnt_row      coordinate of the beat currently on m_axis
//   frame_done            one-cycle pulse after the last pixel of a frame is accepted
//   frame_count           completed frames, wrapping
//   err_sync, err_line_len sticky framing errors
module pixel_coord_tracker #(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int USER_WIDTH      = 2,
    parameter int IN_ROWS         = 20,
    parameter int IN_COLS         = 20,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                                          clk,
    input  logic                                          s_axis_resetn,
    input  logic                                          err_clear,
    input  logic                                          s_axis_tvalid,
    output logic                                          s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0]                    s_axis_tdata,
    input  logic [USER_WIDTH-1:0]                         s_axis_tuser,
    output logic                                          m_axis_tvalid,
    input  logic                                          m_axis_tready,
    output logic [PIXEL_BIT_WIDTH-1:0]                    m_axis_tdata,
    output logic [USER_WIDTH-1:0]                         m_axis_tuser,
    output logic [((IN_COLS > 1) ? $clog2(IN_COLS) : 1)-1:0] cnt_col,
    output logic [((IN_ROWS > 1) ? $clog2(IN_ROWS) : 1)-1:0] cnt_row,
    output logic                                          frame_done,
    output logic [FRAME_CNT_WIDTH-1:0]                    frame_count,
    output logic                                          err_sync,
    output logic                                          err_line_len
);
    // A 1-wide counter stands in when a dimension is 1, so the ports never collapse to zero width.
    localparam int CW = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
    localparam int RW = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
    localparam int BW = PIXEL_BIT_WIDTH + USER_WIDTH + CW + RW;
    localparam logic [CW-1:0] LAST_COL = CW'(IN_COLS - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IN_ROWS - 1);

    typedef enum logic {WAIT_SOF, IN_FRAME} state_t;

    state_t              r_state, w_state_nx;
    logic [CW-1:0]       r_col, w_col_nx, w_col_cur;
    logic [RW-1:0]       r_row, w_row_nx, w_row_cur;
    logic [BW-1:0]       r_main, r_skid, w_beat;
    logic                r_main_v, r_skid_v;
    logic                r_frame_done, r_err_sync, r_err_len;
    logic [FRAME_CNT_WIDTH-1:0] r_frame_count;
    logic                w_accept, w_fwd, w_last_col, w_last, w_sync_ev, w_len_ev;

    assign s_axis_tready = !r_skid_v;
    assign w_accept      = s_axis_tvalid && !r_skid_v;

    // An SOF beat always restarts at (0,0), whether it opens a frame or interrupts one.
    always_comb begin
        w_fwd      = w_accept && (r_state == IN_FRAME || s_axis_tuser[0]);
        w_col_cur  = s_axis_tuser[0] ? '0 : r_col;
        w_row_cur  = s_axis_tuser[0] ? '0 : r_row;
        w_last_col = w_col_cur == LAST_COL;
        w_last     = w_last_col && w_row_cur == LAST_ROW;
        w_sync_ev  = w_accept && ((r_state == WAIT_SOF) ? !s_axis_tuser[0] :
                                  s_axis_tuser[0] && (r_col != '0 || r_row != '0));
        w_len_ev   = w_fwd && (s_axis_tuser[1] != w_last_col);
        w_beat     = {s_axis_tdata, s_axis_tuser, w_col_cur, w_row_cur};
        w_state_nx = r_state;
        w_col_nx   = r_col;
        w_row_nx   = r_row;
        if (w_fwd) begin
            w_state_nx = w_last ? WAIT_SOF : IN_FRAME;
            w_col_nx   = w_last_col ? '0 : w_col_cur + 1'b1;
            w_row_nx   = w_last ? '0 : (w_last_col ? w_row_cur + 1'b1 : w_row_cur);
        end
    end

    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            r_state       <= WAIT_SOF;
            r_col         <= '0;
            r_row         <= '0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_err_sync    <= 1'b0;
            r_err_len     <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_col         <= w_col_nx;
            r_row         <= w_row_nx;
            r_frame_done  <= w_fwd && w_last;
            r_frame_count <= r_frame_count + FRAME_CNT_WIDTH'(w_fwd && w_last);
            r_err_sync    <= w_sync_ev || (r_err_sync && !err_clear);
            r_err_len     <= w_len_ev || (r_err_len && !err_clear);
        end
    end

    // Skid stage: the skid register only fills when the main register is stalled,
    // and drains into main before any new beat is taken.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            r_main   <= '0;
            r_skid   <= '0;
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (r_skid_v) begin
            if (m_axis_tready) begin
                r_main   <= r_skid;
                r_skid_v <= 1'b0;
            end
        end else if (!r_main_v || m_axis_tready) begin
            r_main_v <= w_fwd;
            if (w_fwd) r_main <= w_beat;
        end else if (w_fwd) begin
            r_skid   <= w_beat;
            r_skid_v <= 1'b1;
        end
    end

    assign m_axis_tvalid = r_main_v;
    assign {m_axis_tdata, m_axis_tuser, cnt_col, cnt_row} = r_main;
    assign frame_done    = r_frame_done;
    assign frame_count   = r_frame_count;
    assign err_sync      = r_err_sync;
    assign err_line_len  = r_err_len;
endmodule

// File: tb/tb_pixel_coord_tracker.sv
// tb_pixel_coord_tracker: directed self-checking bench for pixel_coord_tracker with a 5x4 frame.
module tb_pixel_coord_tracker;
    typedef struct packed {
        logic [9:0] d;
        logic [1:0] u;
        logic [2:0] c;
        logic [1:0] r;
    } beat_t;

    logic        clk = 1'b0;
    logic        s_axis_resetn = 1'b0;
    logic        err_clear = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [9:0]  s_axis_tdata = '0;
    logic [1:0]  s_axis_tuser = '0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [9:0]  m_axis_tdata;
    logic [1:0]  m_axis_tuser;
    logic [2:0]  cnt_col;
    logic [1:0]  cnt_row;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        err_sync;
    logic        err_line_len;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_fd = 0;
    bit          rnd = 1'b0;
    bit          prev_stall = 1'b0;
    beat_t       prev_bus;
    logic [9:0]  dseq = 10'h100;
    beat_t       q[$];
    time         t0;

    pixel_coord_tracker #(
        .PIXEL_BIT_WIDTH(10), .USER_WIDTH(2), .IN_ROWS(4), .IN_COLS(5), .FRAME_CNT_WIDTH(16)
    ) dut (
        .clk(clk), .s_axis_resetn(s_axis_resetn), .err_clear(err_clear),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .cnt_col(cnt_col), .cnt_row(cnt_row), .frame_done(frame_done),
        .frame_count(frame_count), .err_sync(err_sync), .err_line_len(err_line_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: samples between edges, checks beats against the expected queue and stall stability.
    always @(negedge clk) begin
        #1;
        if (!s_axis_resetn) prev_stall = 1'b0;
        else begin
            if (prev_stall) begin
                check("stall_valid", 32'(m_axis_tvalid), 32'd1);
                check("stall_bus", 32'({m_axis_tdata, m_axis_tuser, cnt_col, cnt_row}), 32'(prev_bus));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check("beat_expected", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) check("beat", 32'({m_axis_tdata, m_axis_tuser, cnt_col, cnt_row}), 32'(q.pop_front()));
            end
            if (frame_done) n_fd++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_bus   = {m_axis_tdata, m_axis_tuser, cnt_col, cnt_row};
        end
    end

    task automatic send(input logic [1:0] u, input bit fwd, input int c, input int r);
        logic rdy;
        int   n = 0;
        if (fwd) q.push_back({dseq, u, 3'(c), 2'(r)});
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = dseq;
        s_axis_tuser  = u;
        do begin
            if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
            rdy = s_axis_tready;
            @(negedge clk);
            n++;
        end while (!rdy && n < 100);
        if (!rdy) check("send_timeout", 32'(rdy), 32'd1);
        s_axis_tvalid = 1'b0;
        dseq++;
    endtask

    // EOL normally at col 4; a bad_r/bad_c pair moves that row's EOL to bad_c.
    task automatic frame(input int bad_r, input int bad_c);
        logic [1:0] u;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++) begin
                if (rnd) repeat ($urandom_range(0, 1)) begin
                    m_axis_tready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                u = {(c == 4 && r != bad_r) || (c == bad_c && r == bad_r), r == 0 && c == 0};
                send(u, 1'b1, c, r);
                if (!rnd && r == 0 && c == 0)
                    check("latency", 32'({m_axis_tvalid, m_axis_tdata}), 32'({1'b1, dseq - 10'd1}));
            end
    endtask

    task automatic drain();
        int n = 0;
        rnd = 1'b0;
        m_axis_tready = 1'b1;
        while (q.size() > 0 && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("drain", 32'(q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_reset(input bit chk);
        @(negedge clk);
        s_axis_resetn = 1'b0;
        s_axis_tvalid = 1'b0;
        err_clear     = 1'b0;
        q.delete();
        @(negedge clk);
        if (chk) begin
            #2;
            check("rst_outs", 32'({m_axis_tvalid, frame_done, frame_count, err_sync, err_line_len,
                                   cnt_col, cnt_row, m_axis_tdata, m_axis_tuser}), 32'd0);
            check("rst_tready", 32'(s_axis_tready), 32'd1);
        end
        @(negedge clk);
        s_axis_resetn = 1'b1;
        n_fd = 0;
        @(negedge clk);
    endtask

    initial begin
        // 1: two clean back-to-back frames at full rate
        do_reset(1'b1);
        t0 = $time;
        frame(-1, -1);
        frame(-1, -1);
        check("t1_rate", 32'(($time - t0) / 10), 32'd40);
        drain();
        check("t1_count", 32'(frame_count), 32'd2);
        check("t1_done", 32'(n_fd), 32'd2);
        check("t1_errs", 32'({err_sync, err_line_len}), 32'd0);

        // 2: random source gaps and random downstream ready over three frames
        do_reset(1'b0);
        rnd = 1'b1;
        repeat (3) frame(-1, -1);
        drain();
        check("t2_count", 32'(frame_count), 32'd3);
        check("t2_done", 32'(n_fd), 32'd3);
        check("t2_errs", 32'({err_sync, err_line_len}), 32'd0);

        // 3: three beats without SOF are dropped, then a clean frame
        do_reset(1'b0);
        repeat (3) send(2'b00, 1'b0, 0, 0);
        check("t3_sync_early", 32'(err_sync), 32'd1);
        frame(-1, -1);
        drain();
        check("t3_sync", 32'(err_sync), 32'd1);
        check("t3_len", 32'(err_line_len), 32'd0);
        check("t3_count", 32'(frame_count), 32'd1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("t3_clear", 32'(err_sync), 32'd0);
        err_clear = 1'b1;
        send(2'b00, 1'b0, 0, 0);
        err_clear = 1'b0;
        check("t3_clear_vs_event", 32'(err_sync), 32'd1);

        // 4: EOL moved to col 3 of row 1
        do_reset(1'b0);
        frame(1, 3);
        drain();
        check("t4_len", 32'(err_line_len), 32'd1);
        check("t4_sync", 32'(err_sync), 32'd0);
        check("t4_count", 32'(frame_count), 32'd1);

        // 5: SOF injected at (2,2) restarts the frame
        do_reset(1'b0);
        for (int i = 0; i < 12; i++) send({i % 5 == 4, i == 0}, 1'b1, i % 5, i / 5);
        send(2'b01, 1'b1, 0, 0);
        check("t5_sync", 32'(err_sync), 32'd1);
        for (int i = 1; i < 20; i++) begin
            if (i == 19) check("t5_count_before", 32'(frame_count), 32'd0);
            send({i % 5 == 4, 1'b0}, 1'b1, i % 5, i / 5);
        end
        drain();
        check("t5_count", 32'(frame_count), 32'd1);
        check("t5_done", 32'(n_fd), 32'd1);
        check("t5_len", 32'(err_line_len), 32'd0);

        // 6: reset with the skid full mid-frame, then a clean frame
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) send({i % 5 == 4, i == 0}, 1'b1, i % 5, i / 5);
        m_axis_tready = 1'b0;
        send(2'b00, 1'b1, 3, 1);
        check("t6_skid_full", 32'(s_axis_tready), 32'd0);
        do_reset(1'b1);
        m_axis_tready = 1'b1;
        frame(-1, -1);
        drain();
        check("t6_count", 32'(frame_count), 32'd1);
        check("t6_errs", 32'({err_sync, err_line_len}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
